// File: rtl/l1_icache.sv
// Direct-mapped, read-only L1 instruction cache between the fetch stage and
// the shared memory bus. Hits return one cycle after acceptance, and
// back-to-back hits sustain one instruction per cycle. A miss refills the
// whole line in beat order. Flush (fence.i) invalidates every line, one per cycle.
// Optional feature: define ICACHE_PERF_EN to build the hit/miss counters;
// otherwise hit_count/miss_count read as zero.
module l1_icache #(
  parameter int LINES          = 64,
  parameter int WORDS_PER_LINE = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        fe_req,
  input  logic [31:0] fe_addr,
  output logic        fe_ready,
  output logic        fe_valid,
  output logic [31:0] fe_instr,
  input  logic        flush,
  output logic        busy,
  output logic [31:0] bus_addr,
  output logic        bus_ren,
  input  logic [31:0] bus_rdata,
  input  logic        bus_done,
  output logic [31:0] hit_count,
  output logic [31:0] miss_count
);

  localparam int IDX_W = $clog2(LINES);
  localparam int OFF_W = $clog2(WORDS_PER_LINE);
  localparam int TAG_W = 30 - IDX_W - OFF_W;

  typedef enum logic [2:0] {
    S_FLUSH,
    S_IDLE,
    S_LOOKUP,
    S_REFILL,
    S_RESPOND
  } state_e;

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   flush_idx_q, flush_idx_d;
  logic [OFF_W-1:0]   beat_q, beat_d;
  logic               pend_q, pend_d;

  // Word address of the request currently in LOOKUP/REFILL/RESPOND.
  logic [29:0]        addr_q;
  logic [31:0]        rd_data_q;
  logic [TAG_W-1:0]   rd_tag_q;
  logic [31:0]        cap_q;
  logic [31:0]        hold_q;
  logic [LINES-1:0]   valid_q;

  logic [31:0]        data_mem [LINES*WORDS_PER_LINE];
  logic [TAG_W-1:0]   tag_mem  [LINES];

  logic [IDX_W-1:0]   lk_idx;
  logic [OFF_W-1:0]   lk_off;
  logic [TAG_W-1:0]   lk_tag;
  logic [IDX_W-1:0]   req_idx;
  logic               hit;
  logic               lookup_miss;
  logic               accept;
  logic               last_beat;
  logic               refill_beat;
  logic               unused_addr_bits;

  assign lk_off  = addr_q[OFF_W-1:0];
  assign lk_idx  = addr_q[OFF_W +: IDX_W];
  assign lk_tag  = addr_q[29 -: TAG_W];
  assign req_idx = fe_addr[2+OFF_W +: IDX_W];

  // Byte-lane bits of the PC carry no information for word fetches.
  assign unused_addr_bits = ^fe_addr[1:0];

  assign hit         = (state_q == S_LOOKUP) && valid_q[lk_idx] && (rd_tag_q == lk_tag);
  assign lookup_miss = (state_q == S_LOOKUP) && !hit;
  assign fe_ready    = ((state_q == S_IDLE) || hit) && !flush;
  assign accept      = fe_req && fe_ready;
  assign last_beat   = (beat_q == OFF_W'(WORDS_PER_LINE - 1));
  assign refill_beat = rst && (state_q == S_REFILL) && bus_done;

  // FSM state register; reset restarts the full invalidation sweep.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= S_FLUSH;
      flush_idx_q <= '0;
      beat_q      <= '0;
      pend_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      flush_idx_q <= flush_idx_d;
      beat_q      <= beat_d;
      pend_q      <= pend_d;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_d     = state_q;
    flush_idx_d = flush_idx_q;
    beat_d      = beat_q;
    pend_d      = pend_q;
    case (state_q)
      S_FLUSH: begin
        // flush_idx wraps back to zero on the last line, ready for the next sweep.
        flush_idx_d = flush_idx_q + IDX_W'(1);
        if (flush_idx_q == IDX_W'(LINES - 1)) state_d = S_IDLE;
      end
      S_IDLE: begin
        if (accept)     state_d = S_LOOKUP;
        else if (flush) state_d = S_FLUSH;
      end
      S_LOOKUP: begin
        if (hit) begin
          if (accept)     state_d = S_LOOKUP;
          else if (flush) state_d = S_FLUSH;
          else            state_d = S_IDLE;
        end else begin
          // A flush arriving with a miss is deferred until the refill responds.
          state_d = S_REFILL;
          beat_d  = '0;
          pend_d  = flush;
        end
      end
      S_REFILL: begin
        if (flush) pend_d = 1'b1;
        if (bus_done) begin
          beat_d = beat_q + OFF_W'(1);
          if (last_beat) state_d = S_RESPOND;
        end
      end
      S_RESPOND: begin
        pend_d  = 1'b0;
        state_d = (pend_q || flush) ? S_FLUSH : S_IDLE;
      end
      default: state_d = S_FLUSH;
    endcase
  end

  // FSM outputs: fetch response, bus strobe/address and busy indication.
  always_comb begin
    busy     = (state_q == S_FLUSH) || (state_q == S_REFILL) || (state_q == S_RESPOND);
    bus_ren  = 1'b0;
    bus_addr = '0;
    fe_valid = 1'b0;
    fe_instr = hold_q;
    case (state_q)
      S_LOOKUP: begin
        if (hit) begin
          fe_valid = 1'b1;
          fe_instr = rd_data_q;
        end
      end
      S_REFILL: begin
        bus_ren  = 1'b1;
        bus_addr = {addr_q[29:OFF_W], beat_q, 2'b00};
      end
      S_RESPOND: begin
        fe_valid = 1'b1;
        fe_instr = cap_q;
      end
      default: ;
    endcase
  end

  // Request address latch on acceptance.
  always_ff @(posedge clk) begin
    if (accept) addr_q <= fe_addr[31:2];
  end

  // Data RAM: registered read on acceptance, refill writes one word per beat.
  always_ff @(posedge clk) begin
    if (refill_beat) data_mem[{lk_idx, beat_q}] <= bus_rdata;
    if (accept) rd_data_q <= data_mem[fe_addr[2 +: IDX_W+OFF_W]];
  end

  // Tag RAM: registered read on acceptance, written when the last beat lands.
  always_ff @(posedge clk) begin
    if (refill_beat && last_beat) tag_mem[lk_idx] <= lk_tag;
    if (accept) rd_tag_q <= tag_mem[req_idx];
  end

  // Capture the requested word as it streams past during refill.
  always_ff @(posedge clk) begin
    if (refill_beat && (beat_q == lk_off)) cap_q <= bus_rdata;
  end

  // Line valid bits: cleared by the sweep and on miss, set when a refill completes.
  always_ff @(posedge clk) begin
    if (rst) begin
      if (state_q == S_FLUSH) valid_q[flush_idx_q] <= 1'b0;
      if (lookup_miss)        valid_q[lk_idx]      <= 1'b0;
      if (refill_beat && last_beat) valid_q[lk_idx] <= 1'b1;
    end
  end

  // Hold the last delivered instruction between responses.
  always_ff @(posedge clk) begin
    if (!rst)          hold_q <= '0;
    else if (fe_valid) hold_q <= fe_instr;
  end

`ifdef ICACHE_PERF_EN
  logic [31:0] hit_cnt_q;
  logic [31:0] miss_cnt_q;

  // Free-running hit/miss counters, one event per LOOKUP cycle.
  always_ff @(posedge clk) begin
    if (!rst) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      if (hit)         hit_cnt_q  <= hit_cnt_q + 32'd1;
      if (lookup_miss) miss_cnt_q <= miss_cnt_q + 32'd1;
    end
  end

  assign hit_count  = hit_cnt_q;
  assign miss_count = miss_cnt_q;
`else
  assign hit_count  = 32'h0;
  assign miss_count = 32'h0;
`endif

endmodule

// File: tb/tb_l1_icache.sv
// Directed bench for l1_icache: reset sweep, cold miss, back-to-back hits,
// index conflicts, flush during refill, flush racing a request, reset mid-refill.
// Memory word at byte address a is {a[15:0]^16'hBEEF, a[15:0]}.
module tb_l1_icache;

`ifdef ICACHE_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        fe_req;
  logic [31:0] fe_addr;
  logic        fe_ready;
  logic        fe_valid;
  logic [31:0] fe_instr;
  logic        flush;
  logic        busy;
  logic [31:0] bus_addr;
  logic        bus_ren;
  logic [31:0] bus_rdata;
  logic        bus_done;
  logic [31:0] hit_count;
  logic [31:0] miss_count;

  int n_cmp = 0;
  int n_err = 0;

  int          rsp_cnt = 0;
  int          n_beats = 0;
  int          n_valid = 0;
  int          n_ren   = 0;
  logic [31:0] beat_log [64];

  l1_icache dut (
    .clk        (clk),
    .rst        (rst),
    .fe_req     (fe_req),
    .fe_addr    (fe_addr),
    .fe_ready   (fe_ready),
    .fe_valid   (fe_valid),
    .fe_instr   (fe_instr),
    .flush      (flush),
    .busy       (busy),
    .bus_addr   (bus_addr),
    .bus_ren    (bus_ren),
    .bus_rdata  (bus_rdata),
    .bus_done   (bus_done),
    .hit_count  (hit_count),
    .miss_count (miss_count)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] memf(input logic [31:0] a);
    return {a[15:0] ^ 16'hBEEF, a[15:0]};
  endfunction

  // Bus slave: completes a beat every second cycle of bus_ren; also logs activity.
  always @(negedge clk) begin
    if (bus_ren === 1'b1) begin
      rsp_cnt   = rsp_cnt + 1;
      bus_done  = (rsp_cnt % 2 == 0);
      bus_rdata = memf(bus_addr);
      if (bus_done && n_beats < 64) begin
        beat_log[n_beats] = bus_addr;
        n_beats = n_beats + 1;
      end
      n_ren = n_ren + 1;
    end else begin
      rsp_cnt  = 0;
      bus_done = 1'b0;
    end
    if (fe_valid === 1'b1) n_valid = n_valid + 1;
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wait_ready(output int cnt);
    cnt = 0;
    while (fe_ready !== 1'b1 && cnt < 300) begin
      cnt++;
      tick();
    end
  endtask

  task automatic wait_valid(output logic got);
    int k = 0;
    while (fe_valid !== 1'b1 && k < 100) begin
      tick();
      k++;
    end
    got = (fe_valid === 1'b1);
  endtask

  task automatic fetch(input logic [31:0] a, output logic [31:0] instr, output logic got);
    int c;
    wait_ready(c);
    fe_req  = 1'b1;
    fe_addr = a;
    tick();
    fe_req  = 1'b0;
    wait_valid(got);
    instr = fe_instr;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] ins;
    logic        got;
    int          cnt;
    int          b0;
    int          v0;
    int          r0;
    int          k;
    logic        pulsed;

    rst = 1'b0; fe_req = 1'b0; fe_addr = '0; flush = 1'b0;
    bus_done = 1'b0; bus_rdata = '0;
    tick(); tick(); tick();

    // Reset state
    chk("rst_busy",     {31'b0, busy},     32'd1);
    chk("rst_ready",    {31'b0, fe_ready}, 32'd0);
    chk("rst_valid",    {31'b0, fe_valid}, 32'd0);
    chk("rst_instr",    fe_instr,          32'h0);
    chk("rst_ren",      {31'b0, bus_ren},  32'd0);
    chk("rst_busaddr",  bus_addr,          32'h0);
    chk("rst_hits",     hit_count,         32'h0);
    chk("rst_misses",   miss_count,        32'h0);

    // Release: the release cycle itself is the first of the LINES sweep cycles.
    rst = 1'b1;
    wait_ready(cnt);
    chk("init_flush_cycles", 32'(cnt), 32'd64);
    chk("init_ready", {31'b0, fe_ready}, 32'd1);
    chk("init_busy",  {31'b0, busy},     32'd0);
    chk("init_ren",   {31'b0, bus_ren},  32'd0);

    // Cold fetch of 0x100
    b0 = n_beats; v0 = n_valid;
    fetch(32'h100, ins, got);
    chk("cold_got",   {31'b0, got}, 32'd1);
    chk("cold_instr", ins, 32'hBFEF0100);
    chk("cold_beats", 32'(n_beats - b0), 32'd4);
    chk("cold_a0", beat_log[b0],   32'h100);
    chk("cold_a1", beat_log[b0+1], 32'h104);
    chk("cold_a2", beat_log[b0+2], 32'h108);
    chk("cold_a3", beat_log[b0+3], 32'h10C);
    tick();
    chk("cold_pulse_len", 32'(n_valid - v0), 32'd1);
    chk("cold_valid_low", {31'b0, fe_valid}, 32'd0);
    chk("cold_hold", fe_instr, 32'hBFEF0100);
    chk("cold_misses", miss_count, PERF ? 32'd1 : 32'd0);

    // Back-to-back hits on the same line
    r0 = n_ren;
    fe_req = 1'b1; fe_addr = 32'h104;
    tick();
    chk("b2b_v0", {31'b0, fe_valid}, 32'd1);
    chk("b2b_i0", fe_instr, 32'hBFEB0104);
    chk("b2b_rdy0", {31'b0, fe_ready}, 32'd1);
    fe_addr = 32'h108;
    tick();
    chk("b2b_v1", {31'b0, fe_valid}, 32'd1);
    chk("b2b_i1", fe_instr, 32'hBFE70108);
    fe_addr = 32'h10C;
    tick();
    chk("b2b_v2", {31'b0, fe_valid}, 32'd1);
    chk("b2b_i2", fe_instr, 32'hBFE3010C);
    fe_req = 1'b0;
    tick();
    chk("b2b_end", {31'b0, fe_valid}, 32'd0);
    chk("b2b_no_ren", 32'(n_ren - r0), 32'd0);
    chk("b2b_hits", hit_count, PERF ? 32'd3 : 32'd0);

    // Index conflict: 0x100 (hit), 0x1100 and 0x100 again (both refill)
    b0 = n_beats;
    fetch(32'h100, ins, got);
    chk("cf_hit_instr", ins, 32'hBFEF0100);
    chk("cf_hit_beats", 32'(n_beats - b0), 32'd0);
    fetch(32'h1100, ins, got);
    chk("cf_b_got",   {31'b0, got}, 32'd1);
    chk("cf_b_instr", ins, 32'hAFEF1100);
    chk("cf_b_beats", 32'(n_beats - b0), 32'd4);
    chk("cf_b_a0", beat_log[b0],   32'h1100);
    chk("cf_b_a3", beat_log[b0+3], 32'h110C);
    fetch(32'h100, ins, got);
    chk("cf_c_instr", ins, 32'hBFEF0100);
    chk("cf_c_beats", 32'(n_beats - b0), 32'd8);
    chk("cf_misses", miss_count, PERF ? 32'd3 : 32'd0);
    chk("cf_hits",   hit_count,  PERF ? 32'd4 : 32'd0);

    // Flush pulsed during the second beat of a refill of 0x200
    b0 = n_beats;
    wait_ready(cnt);
    fe_req = 1'b1; fe_addr = 32'h200;
    tick();
    fe_req = 1'b0;
    pulsed = 1'b0; k = 0;
    while (fe_valid !== 1'b1 && k < 100) begin
      if (!pulsed && n_beats == b0 + 1 && bus_done === 1'b0 && bus_ren === 1'b1) begin
        flush = 1'b1; pulsed = 1'b1;
        tick();
        flush = 1'b0;
      end else begin
        tick();
      end
      k++;
    end
    chk("fl_got",   {31'b0, fe_valid}, 32'd1);
    chk("fl_instr", fe_instr, 32'hBCEF0200);
    chk("fl_beats", 32'(n_beats - b0), 32'd4);
    tick();
    chk("fl_busy", {31'b0, busy}, 32'd1);
    wait_ready(cnt);
    chk("fl_flush_cycles", 32'(cnt), 32'd64);
    b0 = n_beats;
    fetch(32'h200, ins, got);
    chk("fl_refetch_instr", ins, 32'hBCEF0200);
    chk("fl_refetch_miss",  32'(n_beats - b0), 32'd4);
    chk("fl_misses", miss_count, PERF ? 32'd5 : 32'd0);

    // Flush and request in the same cycle: flush wins
    tick();
    v0 = n_valid;
    fe_req = 1'b1; fe_addr = 32'h200; flush = 1'b1;
    #1;
    chk("race_ready", {31'b0, fe_ready}, 32'd0);
    tick();
    fe_req = 1'b0; flush = 1'b0;
    chk("race_busy",  {31'b0, busy}, 32'd1);
    wait_ready(cnt);
    chk("race_flush_cycles", 32'(cnt), 32'd64);
    chk("race_no_valid", 32'(n_valid - v0), 32'd0);

    // Reset during the third beat of a refill of 0x300
    b0 = n_beats;
    fe_req = 1'b1; fe_addr = 32'h300;
    tick();
    fe_req = 1'b0;
    k = 0;
    while (!(n_beats == b0 + 2 && bus_done === 1'b0 && bus_ren === 1'b1) && k < 100) begin
      tick();
      k++;
    end
    chk("rr_reached_beat3", 32'(n_beats - b0), 32'd2);
    rst = 1'b0;
    tick();
    chk("rr_ren_low", {31'b0, bus_ren}, 32'd0);
    chk("rr_busy",    {31'b0, busy},    32'd1);
    tick();
    chk("rr_hits",   hit_count,  32'h0);
    chk("rr_misses", miss_count, 32'h0);
    rst = 1'b1;
    wait_ready(cnt);
    chk("rr_flush_cycles", 32'(cnt), 32'd64);
    b0 = n_beats;
    fetch(32'h300, ins, got);
    chk("rr_refetch_instr", ins, 32'hBDEF0300);
    chk("rr_refetch_miss",  32'(n_beats - b0), 32'd4);
    chk("rr_misses_after", miss_count, PERF ? 32'd1 : 32'd0);
    chk("rr_hits_after",   hit_count,  32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
